// File: rtl/rr_arbiter_vc.sv
// Round-robin arbiter with NUM_VC independent priority contexts and optional packet lock.
// The grant is combinational from the registered per-context state; lock_err flags a forced stall unlock.
module rr_arbiter_vc #(
    parameter int NUM_REQ      = 5,
    parameter int NUM_VC       = 2,
    parameter int LOCK_EN      = 1,
    parameter int HOLD_TIMEOUT = 0,
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int IW  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VCW-1:0]     vc_sel,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] tail,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IW-1:0]      gnt_idx,
    output logic               locked,
    output logic               lock_err
);

    localparam logic [IW:0]   NR_W      = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] PTR_RST   = IW'(NUM_REQ - 1);
    localparam logic [7:0]    IDLE_LAST = (HOLD_TIMEOUT > 0) ? 8'(HOLD_TIMEOUT - 1) : 8'd0;

    logic [IW-1:0]   ptr_q  [NUM_VC];
    logic [IW-1:0]   own_q  [NUM_VC];
    logic [7:0]      idle_q [NUM_VC];
    logic [NUM_VC-1:0] lk_q;
    logic            lock_err_q;

    logic            vc_ok;
    logic [VCW-1:0]  vc_idx;
    logic [IW-1:0]   cur_ptr;
    logic [IW-1:0]   cur_own;
    logic [7:0]      cur_idle;
    logic            cur_lk;
    logic [IW:0]     sum;
    logic [IW-1:0]   win;
    logic            found;
    logic            gnt_any;

    // Out-of-range contexts only exist when NUM_VC is not a power of two.
    if (NUM_VC >= (1 << VCW)) begin : g_vc_full
        assign vc_ok = 1'b1;
    end else begin : g_vc_part
        assign vc_ok = (vc_sel < VCW'(NUM_VC));
    end

    assign vc_idx   = vc_ok ? vc_sel : '0;
    assign cur_ptr  = ptr_q[vc_idx];
    assign cur_own  = own_q[vc_idx];
    assign cur_idle = idle_q[vc_idx];
    assign cur_lk   = lk_q[vc_idx];

    always_comb begin
        sum   = '0;
        win   = cur_own;
        found = 1'b0;
        if (cur_lk) begin
            found = req[cur_own];
        end else begin
            for (int j = 1; j <= NUM_REQ; j++) begin
                sum = {1'b0, cur_ptr} + (IW+1)'(j);
                if (sum >= NR_W) sum = sum - NR_W;
                if (!found && req[sum[IW-1:0]]) begin
                    found = 1'b1;
                    win   = sum[IW-1:0];
                end
            end
        end
    end

    assign gnt_any   = reset && vc_ok && found;
    assign gnt       = gnt_any ? (NUM_REQ'(1) << win) : '0;
    assign gnt_valid = gnt_any;
    assign gnt_idx   = gnt_any ? win : '0;
    assign locked    = reset && vc_ok && cur_lk;
    assign lock_err  = reset && lock_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                ptr_q[v]  <= PTR_RST;
                own_q[v]  <= '0;
                idle_q[v] <= '0;
            end
            lk_q       <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= 1'b0;
            if (vc_ok) begin
                if (cur_lk) begin
                    if (req[cur_own]) begin
                        idle_q[vc_idx] <= '0;
                        ptr_q[vc_idx]  <= cur_own;
                        if (tail[cur_own]) lk_q[vc_idx] <= 1'b0;
                    end else if (HOLD_TIMEOUT > 0) begin
                        if (cur_idle == IDLE_LAST) begin
                            lk_q[vc_idx]   <= 1'b0;
                            idle_q[vc_idx] <= '0;
                            lock_err_q     <= 1'b1;
                        end else if (cur_idle != 8'hFF) begin
                            idle_q[vc_idx] <= cur_idle + 8'd1;
                        end
                    end
                end else if (found) begin
                    ptr_q[vc_idx] <= win;
                    // Single-flit packets never take the lock.
                    if (LOCK_EN != 0 && !tail[win]) begin
                        lk_q[vc_idx]   <= 1'b1;
                        own_q[vc_idx]  <= win;
                        idle_q[vc_idx] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_vc.sv
// Bench for rr_arbiter_vc: two instances (5-way locking with timeout, 3-way non-locking)
// driven together and compared against a list-scan reference model.
module tb_rr_arbiter_vc;

    logic       clk;
    logic       reset;
    logic [1:0] vc_sel;
    logic [4:0] req_a, tail_a, gnt_a;
    logic [2:0] req_b, tail_b, gnt_b;
    logic [2:0] gnt_idx_a;
    logic [1:0] gnt_idx_b;
    logic       gnt_valid_a, gnt_valid_b, locked_a, locked_b, lock_err_a, lock_err_b;

    int errors = 0;
    int checks = 0;

    rr_arbiter_vc #(.NUM_REQ(5), .NUM_VC(3), .LOCK_EN(1), .HOLD_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .vc_sel(vc_sel), .req(req_a), .tail(tail_a),
        .gnt(gnt_a), .gnt_valid(gnt_valid_a), .gnt_idx(gnt_idx_a),
        .locked(locked_a), .lock_err(lock_err_a));

    rr_arbiter_vc #(.NUM_REQ(3), .NUM_VC(3), .LOCK_EN(0), .HOLD_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .vc_sel(vc_sel), .req(req_b), .tail(tail_b),
        .gnt(gnt_b), .gnt_valid(gnt_valid_b), .gnt_idx(gnt_idx_b),
        .locked(locked_b), .lock_err(lock_err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance k, per context v.
    int P_NR[2] = '{5, 3};
    int P_LE[2] = '{1, 0};
    int P_HT[2] = '{4, 0};
    int m_ptr[2][3];
    int m_own[2][3];
    int m_idle[2][3];
    bit m_lk[2][3];
    bit m_lerr[2];

    logic       cur_rst;
    int         cur_v;
    logic [4:0] cur_ra, cur_ta;
    logic [2:0] cur_rb, cur_tb;

    logic [4:0] exp_gnt_a;
    logic [2:0] exp_gnt_b;
    logic [2:0] exp_idx_a;
    logic [1:0] exp_idx_b;
    logic       exp_val_a, exp_val_b, exp_lk_a, exp_lk_b, exp_err_a, exp_err_b;

    function automatic int mdl_win(int k, int v, logic [4:0] r);
        if (v >= 3) return -1;
        if (m_lk[k][v]) return r[m_own[k][v]] ? m_own[k][v] : -1;
        for (int j = 1; j <= P_NR[k]; j++) begin
            int c;
            c = (m_ptr[k][v] + j) % P_NR[k];
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void mdl_step(int k, logic rst, int v, logic [4:0] r, logic [4:0] t);
        int w;
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                m_ptr[k][c] = P_NR[k] - 1; m_lk[k][c] = 0; m_own[k][c] = 0; m_idle[k][c] = 0;
            end
            m_lerr[k] = 0;
            return;
        end
        m_lerr[k] = 0;
        if (v >= 3) return;
        w = mdl_win(k, v, r);
        if (m_lk[k][v]) begin
            if (r[m_own[k][v]]) begin
                m_idle[k][v] = 0;
                m_ptr[k][v]  = m_own[k][v];
                if (t[m_own[k][v]]) m_lk[k][v] = 0;
            end else if (P_HT[k] > 0) begin
                if (m_idle[k][v] == P_HT[k] - 1) begin
                    m_lk[k][v] = 0; m_idle[k][v] = 0; m_lerr[k] = 1;
                end else if (m_idle[k][v] < 255) begin
                    m_idle[k][v]++;
                end
            end
        end else if (w >= 0) begin
            m_ptr[k][v] = w;
            if (P_LE[k] != 0 && !t[w]) begin
                m_lk[k][v] = 1; m_own[k][v] = w; m_idle[k][v] = 0;
            end
        end
    endfunction

    // Drive one cycle's inputs and derive the expected outputs from the model.
    task automatic apply(input logic rst, input int v, input logic [4:0] ra, input logic [4:0] ta,
                         input logic [2:0] rb, input logic [2:0] tb);
        int wa, wb;
        reset = rst; vc_sel = 2'(v); req_a = ra; tail_a = ta; req_b = rb; tail_b = tb;
        cur_rst = rst; cur_v = v; cur_ra = ra; cur_ta = ta; cur_rb = rb; cur_tb = tb;
        wa = rst ? mdl_win(0, v, ra) : -1;
        wb = rst ? mdl_win(1, v, {2'b00, rb}) : -1;
        exp_val_a = (wa >= 0);
        exp_val_b = (wb >= 0);
        exp_gnt_a = exp_val_a ? 5'(1 << wa) : 5'd0;
        exp_gnt_b = exp_val_b ? 3'(1 << wb) : 3'd0;
        exp_idx_a = exp_val_a ? 3'(wa) : 3'd0;
        exp_idx_b = exp_val_b ? 2'(wb) : 2'd0;
        exp_lk_a  = (rst && v < 3) ? m_lk[0][v] : 1'b0;
        exp_lk_b  = (rst && v < 3) ? m_lk[1][v] : 1'b0;
        exp_err_a = rst ? m_lerr[0] : 1'b0;
        exp_err_b = rst ? m_lerr[1] : 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step(0, cur_rst, cur_v, cur_ra, cur_ta);
        mdl_step(1, cur_rst, cur_v, {2'b00, cur_rb}, {2'b00, cur_tb});
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, $urandom_range(0, 3), 5'($urandom), 5'($urandom), 3'($urandom), 3'($urandom));
            checks++;
            if ({gnt_a, gnt_valid_a, gnt_idx_a, locked_a, lock_err_a} !== 11'd0) begin
                errors++; $display("FAIL reset_a cyc=%0d got=%b exp=0", i,
                                   {gnt_a, gnt_valid_a, gnt_idx_a, locked_a, lock_err_a});
            end
            checks++;
            if ({gnt_b, gnt_valid_b, gnt_idx_b, locked_b, lock_err_b} !== 8'd0) begin
                errors++; $display("FAIL reset_b cyc=%0d got=%b exp=0", i,
                                   {gnt_b, gnt_valid_b, gnt_idx_b, locked_b, lock_err_b});
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int ea[6] = '{0, 1, 2, 3, 4, 0};
        int eb[6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 0, 5'b11111, 5'b11111, 3'b111, 3'b111);
            checks++;
            if (gnt_idx_a !== 3'(ea[i])) begin
                errors++; $display("FAIL rot_idx_a cyc=%0d got=%0d exp=%0d", i, gnt_idx_a, ea[i]);
            end
            checks++;
            if (gnt_idx_b !== 2'(eb[i])) begin
                errors++; $display("FAIL rot_idx_b cyc=%0d got=%0d exp=%0d", i, gnt_idx_b, eb[i]);
            end
            checks++;
            if (gnt_a !== exp_gnt_a || locked_a !== 1'b0) begin
                errors++; $display("FAIL rot_gnt_a cyc=%0d got=%b/%b exp=%b/0", i, gnt_a, locked_a, exp_gnt_a);
            end
            tick();
        end
    endtask

    task automatic test_vc_independent();
        int ea[6] = '{0, 0, 4, 4, 0, 0};
        apply(1'b0, 0, 5'd0, 5'd0, 3'd0, 3'd0); tick();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, i % 2, 5'b10001, 5'b11111, 3'd0, 3'd0);
            checks++;
            if (gnt_idx_a !== 3'(ea[i]) || gnt_valid_a !== 1'b1) begin
                errors++; $display("FAIL vc_idx cyc=%0d vc=%0d got=%0d/%b exp=%0d/1", i, i % 2,
                                   gnt_idx_a, gnt_valid_a, ea[i]);
            end
            checks++;
            if (gnt_a !== exp_gnt_a) begin
                errors++; $display("FAIL vc_gnt cyc=%0d got=%b exp=%b", i, gnt_a, exp_gnt_a);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        int         ei[5] = '{0, 0, 0, 0, 1};
        logic [4:0] el    = 5'b01110;
        logic [4:0] tl    = 5'b01000;
        apply(1'b0, 0, 5'd0, 5'd0, 3'd0, 3'd0); tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 0, 5'b00011, tl[i] ? 5'b00001 : 5'b00000, 3'd0, 3'd0);
            checks++;
            if (gnt_idx_a !== 3'(ei[i]) || locked_a !== el[i]) begin
                errors++; $display("FAIL lock cyc=%0d got idx=%0d lk=%b exp idx=%0d lk=%b", i,
                                   gnt_idx_a, locked_a, ei[i], el[i]);
            end
            checks++;
            if (gnt_a !== exp_gnt_a || locked_a !== exp_lk_a) begin
                errors++; $display("FAIL lock_mdl cyc=%0d got=%b/%b exp=%b/%b", i, gnt_a, locked_a,
                                   exp_gnt_a, exp_lk_a);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int         ei[6] = '{2, 0, 0, 0, 0, 3};
        logic [5:0] ev    = 6'b100001;
        logic [5:0] ee    = 6'b100000;
        apply(1'b0, 0, 5'd0, 5'd0, 3'd0, 3'd0); tick();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 0, (i == 0) ? 5'b00100 : 5'b01000, 5'd0, 3'd0, 3'd0);
            checks++;
            if (gnt_idx_a !== 3'(ei[i]) || gnt_valid_a !== ev[i] || lock_err_a !== ee[i]) begin
                errors++; $display("FAIL timeout cyc=%0d got idx=%0d v=%b err=%b exp idx=%0d v=%b err=%b",
                                   i, gnt_idx_a, gnt_valid_a, lock_err_a, ei[i], ev[i], ee[i]);
            end
            checks++;
            if (locked_a !== exp_lk_a || lock_err_a !== exp_err_a) begin
                errors++; $display("FAIL timeout_mdl cyc=%0d got lk=%b err=%b exp lk=%b err=%b", i,
                                   locked_a, lock_err_a, exp_lk_a, exp_err_a);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 0, 5'd0, 5'd0, 3'd0, 3'd0); tick();
        apply(1'b1, 0, 5'b00010, 5'd0, 3'd0, 3'd0); tick();
        apply(1'b1, 0, 5'b00010, 5'd0, 3'd0, 3'd0);
        checks++;
        if (locked_a !== 1'b1 || gnt_idx_a !== 3'd1) begin
            errors++; $display("FAIL rmid_pre got lk=%b idx=%0d exp lk=1 idx=1", locked_a, gnt_idx_a);
        end
        tick();
        apply(1'b0, 0, 5'b00011, 5'd0, 3'd0, 3'd0);
        checks++;
        if (gnt_a !== 5'd0 || locked_a !== 1'b0) begin
            errors++; $display("FAIL rmid_hold got gnt=%b lk=%b exp gnt=0 lk=0", gnt_a, locked_a);
        end
        tick();
        apply(1'b1, 0, 5'b00011, 5'd0, 3'd0, 3'd0);
        checks++;
        if (locked_a !== 1'b0 || gnt_idx_a !== 3'd0 || gnt_valid_a !== 1'b1) begin
            errors++; $display("FAIL rmid_post got lk=%b idx=%0d v=%b exp lk=0 idx=0 v=1",
                               locked_a, gnt_idx_a, gnt_valid_a);
        end
        tick();
    endtask

    task automatic test_invalid_vc();
        int vs[4] = '{0, 0, 3, 0};
        int eb[4] = '{0, 1, -1, 2};
        int ea[4] = '{0, 1, -1, 2};
        apply(1'b0, 0, 5'd0, 5'd0, 3'd0, 3'd0); tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, vs[i], 5'b11111, 5'b11111, 3'b111, 3'b111);
            checks++;
            if (gnt_valid_b !== (eb[i] >= 0) || (eb[i] >= 0 && gnt_idx_b !== 2'(eb[i]))) begin
                errors++; $display("FAIL invvc_b cyc=%0d got v=%b idx=%0d exp idx=%0d", i,
                                   gnt_valid_b, gnt_idx_b, eb[i]);
            end
            checks++;
            if (gnt_valid_a !== (ea[i] >= 0) || (ea[i] >= 0 && gnt_idx_a !== 3'(ea[i]))) begin
                errors++; $display("FAIL invvc_a cyc=%0d got v=%b idx=%0d exp idx=%0d", i,
                                   gnt_valid_a, gnt_idx_a, ea[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic       rst;
            logic [4:0] ra, ta;
            logic [2:0] rb, tb;
            rst = ($urandom_range(0, 49) != 0);
            ra  = (i % 100 < 50) ? 5'($urandom) : 5'($urandom) & 5'($urandom) & 5'($urandom);
            ta  = 5'($urandom) & 5'($urandom);
            rb  = 3'($urandom);
            tb  = 3'($urandom);
            apply(rst, (i % 7 == 0) ? int'($urandom_range(0, 3)) : cur_v, ra, ta, rb, tb);
            checks++;
            if ({gnt_a, gnt_valid_a, gnt_idx_a, locked_a, lock_err_a} !==
                {exp_gnt_a, exp_val_a, exp_idx_a, exp_lk_a, exp_err_a}) begin
                errors++; $display("FAIL rand_a cyc=%0d got=%b exp=%b", i,
                                   {gnt_a, gnt_valid_a, gnt_idx_a, locked_a, lock_err_a},
                                   {exp_gnt_a, exp_val_a, exp_idx_a, exp_lk_a, exp_err_a});
            end
            checks++;
            if ({gnt_b, gnt_valid_b, gnt_idx_b, locked_b, lock_err_b} !==
                {exp_gnt_b, exp_val_b, exp_idx_b, exp_lk_b, exp_err_b}) begin
                errors++; $display("FAIL rand_b cyc=%0d got=%b exp=%b", i,
                                   {gnt_b, gnt_valid_b, gnt_idx_b, locked_b, lock_err_b},
                                   {exp_gnt_b, exp_val_b, exp_idx_b, exp_lk_b, exp_err_b});
            end
            tick();
        end
    endtask

    initial begin
        cur_v = 0;
        test_reset();
        test_rotation();
        test_vc_independent();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_invalid_vc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
